// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
// Optional overflow reporting is enabled with the TICK_SCHED_OVF_EN macro.
package tick_sched_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   localparam int NCH_DEFAULT = 4;
   localparam int DIV_DEFAULT = 21;
   localparam int CW_DEFAULT  = 8;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_chan.sv
// One countdown timer channel driven by the shared prescaler tick.
// With TICK_SCHED_OVF_EN defined, an extra sticky overflow flag is kept.
module tick_chan
   import tick_sched_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          wr_en,
   input  logic [CW-1:0] wr_load,
   input  logic          wr_periodic,
   input  logic          ack,
   output logic          active,
   output logic          pend,
   output logic          expire,
   output logic          periodic
`ifdef TICK_SCHED_OVF_EN
   ,output logic         ovf
`endif
);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] reload_reg;
   logic          periodic_reg;
   logic          active_reg;
   logic          pend_reg;

   // Writes never coincide with a tick (the port stalls then), but a write
   // is still given priority so a restart never reports the old count.
   assign expire   = tick && active_reg && !wr_en && (count_reg == CW'(1));
   assign active   = active_reg;
   assign pend     = pend_reg;
   assign periodic = periodic_reg;

   // Countdown, reload and enable state of the channel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg    <= '0;
         reload_reg   <= '0;
         periodic_reg <= 1'b0;
         active_reg   <= 1'b0;
      end else if (wr_en) begin
         if (wr_load != '0) begin
            count_reg    <= wr_load;
            reload_reg   <= wr_load;
            periodic_reg <= wr_periodic;
            active_reg   <= 1'b1;
         end else begin
            count_reg  <= '0;
            active_reg <= 1'b0;
         end
      end else if (tick && active_reg) begin
         if (count_reg == CW'(1)) begin
            if (periodic_reg) begin
               count_reg <= reload_reg;
            end else begin
               count_reg  <= '0;
               active_reg <= 1'b0;
            end
         end else begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

   // Sticky pending flag; a new expiry beats an acknowledge on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_reg <= 1'b0;
      end else begin
         pend_reg <= expire | (pend_reg & ~ack);
      end
   end

`ifdef TICK_SCHED_OVF_EN
   logic ovf_reg;
   logic ovf_set;

   assign ovf_set = expire && pend_reg && !ack;
   assign ovf     = ovf_reg;

   // Sticky overflow flag: expiry while the previous one is still unacked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else begin
         ovf_reg <= ovf_set | (ovf_reg & ~ack);
      end
   end
`endif

endmodule

// File: rtl/tick_sched.sv
// Shared-prescaler timer scheduler: one divider, NCH countdown channels,
// single valid/ready configuration port, sticky expiry flags.
// Define TICK_SCHED_OVF_EN to add the exp_ovf output.
module tick_sched
   import tick_sched_pkg::*;
#(
   parameter int NCH = NCH_DEFAULT,
   parameter int DIV = DIV_DEFAULT,
   parameter int CW  = CW_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [clog2_min1(NCH)-1:0]  req_ch,
   input  logic [CW-1:0]               req_load,
   input  logic                        req_periodic,
   input  logic [NCH-1:0]              exp_ack,
   output logic [NCH-1:0]              exp_pend,
   output logic [NCH-1:0]              active,
   output logic                        running
`ifdef TICK_SCHED_OVF_EN
   ,output logic [NCH-1:0]             exp_ovf
`endif
);

   localparam int IW = clog2_min1(NCH);
   localparam int PW = clog2_min1(DIV);
   localparam logic [PW-1:0] CNT_LAST = PW'(DIV - 1);

   state_t        state_reg, state_next;
   logic [PW-1:0] cnt_reg, cnt_next;
   logic          tick;
   logic          accept;
   logic          load_nz;
   logic          start;
   logic [NCH-1:0] wr_en;
   logic [NCH-1:0] expire;
   logic [NCH-1:0] periodic;
   logic [NCH-1:0] post_active;

   assign tick      = (state_reg == RUN) && (cnt_reg == CNT_LAST);
   assign req_ready = !tick;
   assign accept    = req_valid && req_ready;
   assign load_nz   = (req_load != '0);
   // Out-of-range channel numbers match no channel and so start nothing.
   assign start     = (|wr_en) && load_nz;
   assign running   = (state_reg == RUN);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr_en[gi] = accept && (req_ch == IW'(gi));

      tick_chan #(.CW(CW)) u_chan (
         .clk         (clk),
         .rst         (rst),
         .tick        (tick),
         .wr_en       (wr_en[gi]),
         .wr_load     (req_load),
         .wr_periodic (req_periodic),
         .ack         (exp_ack[gi]),
         .active      (active[gi]),
         .pend        (exp_pend[gi]),
         .expire      (expire[gi]),
         .periodic    (periodic[gi])
`ifdef TICK_SCHED_OVF_EN
         ,.ovf        (exp_ovf[gi])
`endif
      );

      // Channel activity as it will be after this edge.
      assign post_active[gi] = wr_en[gi] ? load_nz
                             : (active[gi] && !(expire[gi] && !periodic[gi]));
   end

   // Prescaler phase and run/idle state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Start on the first non-zero write, stop once no channel remains active.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (post_active == '0) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
               cnt_next = '0;
            end else begin
               cnt_next = cnt_reg + PW'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with NCH=4, DIV=4, CW=8.
// Overflow scenario runs only when TICK_SCHED_OVF_EN is defined.
module tb_tick_sched;

   localparam int NCH = 4;
   localparam int DIV = 4;
   localparam int CW  = 8;

   logic           clk;
   logic           rst;
   logic           req_valid;
   logic           req_ready;
   logic [1:0]     req_ch;
   logic [CW-1:0]  req_load;
   logic           req_periodic;
   logic [NCH-1:0] exp_ack;
   logic [NCH-1:0] exp_pend;
   logic [NCH-1:0] active;
   logic           running;
`ifdef TICK_SCHED_OVF_EN
   logic [NCH-1:0] exp_ovf;
`endif

   int checks = 0;
   int errors = 0;

   tick_sched #(.NCH(NCH), .DIV(DIV), .CW(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_ch       (req_ch),
      .req_load     (req_load),
      .req_periodic (req_periodic),
      .exp_ack      (exp_ack),
      .exp_pend     (exp_pend),
      .active       (active),
      .running      (running)
`ifdef TICK_SCHED_OVF_EN
      ,.exp_ovf     (exp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one config write and return 1 ns after its accepting edge.
   task automatic write(input int ch, input int load, input bit per);
      int guard;
      req_valid    = 1'b1;
      req_ch       = 2'(ch);
      req_load     = CW'(load);
      req_periodic = per;
      guard = 0;
      while (!req_ready && guard < 100) begin
         step(1);
         guard++;
      end
      checks++;
      if (guard >= 100) begin
         errors++;
         $display("FAIL write_ready_timeout ch=%0d got ready=%b want 1", ch, req_ready);
      end
      step(1);
      req_valid = 1'b0;
      $display("write ch=%0d load=%0d periodic=%0d t=%0t", ch, load, per, $time);
   endtask

   // Pulse the acknowledge bits for one edge.
   task automatic ack(input logic [NCH-1:0] mask);
      exp_ack = mask;
      step(1);
      exp_ack = '0;
      $display("ack mask=%b t=%0t", mask, $time);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req_valid = 1'b0; req_ch = '0; req_load = '0; req_periodic = 1'b0; exp_ack = '0;
      step(2);
      rst = 1'b0;
      step(1);
      checks++;
      if ({exp_pend, active, running, req_ready} !== {4'b0, 4'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got pend=%b act=%b run=%b rdy=%b want 0 0 0 1",
                  exp_pend, active, running, req_ready);
      end
`ifdef TICK_SCHED_OVF_EN
      checks++;
      if (exp_ovf !== 4'b0) begin
         errors++;
         $display("FAIL reset_ovf got %b want 0000", exp_ovf);
      end
`endif
   endtask

   task automatic test_oneshot;
      write(0, 3, 1'b0);                     // accept edge E0
      checks++;
      if (active !== 4'b0001 || running !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_start got act=%b run=%b want 0001 1", active, running);
      end
      step(11);                              // E0+11
      checks++;
      if (exp_pend !== 4'b0000 || active !== 4'b0001) begin
         errors++;
         $display("FAIL oneshot_early got pend=%b act=%b want 0000 0001", exp_pend, active);
      end
      step(1);                               // E0+12
      checks++;
      if (exp_pend !== 4'b0001 || active !== 4'b0000 || running !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_expire got pend=%b act=%b run=%b want 0001 0000 0",
                  exp_pend, active, running);
      end
      ack(4'b0001);
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL oneshot_ack got pend=%b want 0000", exp_pend);
      end
   endtask

   task automatic test_periodic;
      write(1, 2, 1'b1);                     // E0
      step(7);                               // E0+7
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL periodic_early got pend=%b want 0000", exp_pend);
      end
      step(1);                               // E0+8
      checks++;
      if (exp_pend !== 4'b0010 || active !== 4'b0010 || running !== 1'b1) begin
         errors++;
         $display("FAIL periodic_first got pend=%b act=%b run=%b want 0010 0010 1",
                  exp_pend, active, running);
      end
      ack(4'b0010);                          // E0+9
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL periodic_ack got pend=%b want 0000", exp_pend);
      end
      step(6);                               // E0+15
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL periodic_gap got pend=%b want 0000", exp_pend);
      end
      step(1);                               // E0+16
      checks++;
      if (exp_pend !== 4'b0010) begin
         errors++;
         $display("FAIL periodic_second got pend=%b want 0010", exp_pend);
      end
      write(1, 0, 1'b0);                     // cancel
      checks++;
      if (active !== 4'b0000 || running !== 1'b0 || exp_pend !== 4'b0010) begin
         errors++;
         $display("FAIL periodic_cancel got act=%b run=%b pend=%b want 0000 0 0010",
                  active, running, exp_pend);
      end
      ack(4'b0010);
      step(20);
      checks++;
      if (exp_pend !== 4'b0000 || running !== 1'b0) begin
         errors++;
         $display("FAIL periodic_quiet got pend=%b run=%b want 0000 0", exp_pend, running);
      end
   endtask

   task automatic test_back_to_back;
      logic exp_rdy;
      write(2, 5, 1'b0);                     // E0, prescaler phase 0
      step(2);                               // E0+2, phase 2
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_phase2 got rdy=%b want 1", req_ready);
      end
      step(1);                               // E0+3, phase 3 = tick cycle
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL stall_tick got rdy=%b want 0", req_ready);
      end
      req_valid = 1'b1; req_ch = 2'd3; req_load = 8'd2; req_periodic = 1'b0;
      step(1);                               // E0+4, stalled
      checks++;
      if (active[3] !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold got act3=%b rdy=%b want 0 1", active[3], req_ready);
      end
      step(1);                               // E0+5, accepted
      req_valid = 1'b0;
      $display("write ch=3 load=2 periodic=0 t=%0t", $time);
      checks++;
      if (active[3] !== 1'b1) begin
         errors++;
         $display("FAIL stall_accept got act3=%b want 1", active[3]);
      end
      for (int k = 6; k <= 20; k++) begin
         step(1);
         exp_rdy = ((k % 4) != 3);
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ready_pattern k=%0d got %b want %b", k, req_ready, exp_rdy);
         end
         if (k == 11) begin
            checks++;
            if (exp_pend[3] !== 1'b0) begin
               errors++;
               $display("FAIL ch3_early got %b want 0", exp_pend[3]);
            end
         end
         if (k == 12) begin
            checks++;
            if (exp_pend[3] !== 1'b1 || active[3] !== 1'b0) begin
               errors++;
               $display("FAIL ch3_expire got pend3=%b act3=%b want 1 0", exp_pend[3], active[3]);
            end
         end
         if (k == 19) begin
            checks++;
            if (exp_pend[2] !== 1'b0 || running !== 1'b1) begin
               errors++;
               $display("FAIL ch2_early got pend2=%b run=%b want 0 1", exp_pend[2], running);
            end
         end
         if (k == 20) begin
            checks++;
            if (exp_pend !== 4'b1100 || active !== 4'b0000 || running !== 1'b0) begin
               errors++;
               $display("FAIL ch2_expire got pend=%b act=%b run=%b want 1100 0000 0",
                        exp_pend, active, running);
            end
         end
      end
      ack(4'b1100);
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_ack got pend=%b want 0000", exp_pend);
      end
   endtask

   task automatic test_ack_collision;
      write(0, 1, 1'b1);                     // E0
      step(4);                               // E0+4
      checks++;
      if (exp_pend !== 4'b0001) begin
         errors++;
         $display("FAIL coll_first got pend=%b want 0001", exp_pend);
      end
      step(3);                               // E0+7
      exp_ack = 4'b0001;
      step(1);                               // E0+8: expiry and ack together
      exp_ack = '0;
      checks++;
      if (exp_pend !== 4'b0001) begin
         errors++;
         $display("FAIL coll_set_wins got pend=%b want 0001", exp_pend);
      end
`ifdef TICK_SCHED_OVF_EN
      checks++;
      if (exp_ovf !== 4'b0000) begin
         errors++;
         $display("FAIL coll_ovf got ovf=%b want 0000", exp_ovf);
      end
`endif
      write(0, 0, 1'b0);
      ack(4'b0001);
      checks++;
      if (exp_pend !== 4'b0000) begin
         errors++;
         $display("FAIL coll_ack_alone got pend=%b want 0000", exp_pend);
      end
      ack(4'b0001);
      checks++;
      if (exp_pend !== 4'b0000 || running !== 1'b0) begin
         errors++;
         $display("FAIL coll_ack_clear got pend=%b run=%b want 0000 0", exp_pend, running);
      end
   endtask

   task automatic test_async_reset;
      write(0, 1, 1'b1);                     // E0
      write(2, 1, 1'b1);                     // E0+1
      step(5);                               // E0+6, both expired at E0+4
      checks++;
      if (exp_pend !== 4'b0101 || active !== 4'b0101) begin
         errors++;
         $display("FAIL pre_reset got pend=%b act=%b want 0101 0101", exp_pend, active);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (exp_pend !== 4'b0 || active !== 4'b0 || running !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset got pend=%b act=%b run=%b rdy=%b want 0 0 0 1",
                  exp_pend, active, running, req_ready);
      end
      #2;
      rst = 1'b0;
      step(20);
      checks++;
      if (exp_pend !== 4'b0 || active !== 4'b0 || running !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got pend=%b act=%b run=%b want 0 0 0",
                  exp_pend, active, running);
      end
   endtask

`ifdef TICK_SCHED_OVF_EN
   task automatic test_ovf;
      write(0, 1, 1'b1);                     // E0
      step(4);                               // E0+4
      checks++;
      if (exp_pend !== 4'b0001 || exp_ovf !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_first got pend=%b ovf=%b want 0001 0000", exp_pend, exp_ovf);
      end
      step(4);                               // E0+8
      checks++;
      if (exp_ovf !== 4'b0001) begin
         errors++;
         $display("FAIL ovf_set got ovf=%b want 0001", exp_ovf);
      end
      ack(4'b0001);                          // E0+9, no expiry here
      checks++;
      if (exp_pend !== 4'b0000 || exp_ovf !== 4'b0000) begin
         errors++;
         $display("FAIL ovf_clear got pend=%b ovf=%b want 0000 0000", exp_pend, exp_ovf);
      end
      write(0, 0, 1'b0);
      ack(4'b0001);
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_back_to_back();
      test_ack_collision();
      test_async_reset();
`ifdef TICK_SCHED_OVF_EN
      test_ovf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
